alu_rs: RTL

- Reservation station and issue scheduler for the single-cycle integer ALU.
- Accepts decoded ALU-class instructions from the dispatch stage and holds them until both source operands are available. Operands arrive via capture at dispatch or via two CDB broadcast ports.
- Issues at most one ready instruction per cycle to the ALU, oldest first, driving the ALU's yes/op/v1/v2/pc/is_short/imm/rob_id inputs from registers.

---
 rtl/alu_rs.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// alu_rs : reservation station and issue scheduler for the single-cycle ALU.
//
// Holds decoded ALU-class instructions until both source operands are known,
// then issues at most one ready instruction per cycle, oldest first, into a
// registered ALU input bundle.
//
// Ports
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   rdy_in                      global enable (0 freezes all state)
//   flush_in                    discard every held instruction
//   disp_*                      dispatch bundle (op, q1/q2 tags + values,
//                               pc, is_short, imm, destination rob id)
//   cdb0_* / cdb1_*             result broadcasts (cdb0 has priority)
//   full                        every entry occupied
//   alu_yes, alu_*              registered issue strobe and operands
module alu_rs #(
  parameter int RS_SIZE = 8,
  parameter int ROB_W   = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             disp_valid,
  input  logic [10:0]      disp_op,
  input  logic             disp_q1_busy,
  input  logic [ROB_W-1:0] disp_q1,
  input  logic [31:0]      disp_v1,
  input  logic             disp_q2_busy,
  input  logic [ROB_W-1:0] disp_q2,
  input  logic [31:0]      disp_v2,
  input  logic [31:0]      disp_pc,
  input  logic             disp_is_short,
  input  logic [31:0]      disp_imm,
  input  logic [ROB_W-1:0] disp_rob_id,
  input  logic             cdb0_valid,
  input  logic [ROB_W-1:0] cdb0_rob_id,
  input  logic [31:0]      cdb0_value,
  input  logic             cdb1_valid,
  input  logic [ROB_W-1:0] cdb1_rob_id,
  input  logic [31:0]      cdb1_value,
  output logic             full,
  output logic             alu_yes,
  output logic [10:0]      alu_op,
  output logic [31:0]      alu_v1,
  output logic [31:0]      alu_v2,
  output logic [31:0]      alu_pc,
  output logic             alu_is_short,
  output logic [31:0]      alu_imm,
  output logic [ROB_W-1:0] alu_rob_id
);

  localparam int IDX_W = $clog2(RS_SIZE);

  // Entry state. Occupancy and the age matrix are control and are reset;
  // the payload is only meaningful while its entry is valid.
  logic [RS_SIZE-1:0] valid_q;
  logic [RS_SIZE-1:0] age_q [RS_SIZE];
  logic [RS_SIZE-1:0] q1_busy_q;
  logic [RS_SIZE-1:0] q2_busy_q;
  logic [10:0]        op_q     [RS_SIZE];
  logic [ROB_W-1:0]   q1_q     [RS_SIZE];
  logic [ROB_W-1:0]   q2_q     [RS_SIZE];
  logic [31:0]        v1_q     [RS_SIZE];
  logic [31:0]        v2_q     [RS_SIZE];
  logic [31:0]        pc_q     [RS_SIZE];
  logic [31:0]        imm_q    [RS_SIZE];
  logic [RS_SIZE-1:0] short_q;
  logic [ROB_W-1:0]   rob_q    [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic [RS_SIZE-1:0] sel_oh;
  logic [IDX_W-1:0]   alloc_idx;
  logic               do_disp;
  logic [RS_SIZE-1:0] valid_nxt;
  logic [RS_SIZE-1:0] age_nxt [RS_SIZE];

  // Lowest-index free slot; only used when the station is not full.
  function automatic logic [IDX_W-1:0] first_free(input logic [RS_SIZE-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Operand capture from the broadcast buses: returns {busy, value}.
  // A pending operand whose tag matches a valid broadcast takes that value;
  // cdb0 is checked first so it wins a double match.
  function automatic logic [32:0] capture(input logic             busy,
                                          input logic [ROB_W-1:0] tag,
                                          input logic [31:0]      val);
    logic [32:0] res;
    res = {busy, val};
    if (busy) begin
      if (cdb0_valid && (cdb0_rob_id == tag))      res = {1'b0, cdb0_value};
      else if (cdb1_valid && (cdb1_rob_id == tag)) res = {1'b0, cdb1_value};
    end
    return res;
  endfunction

  assign full      = &valid_q;
  assign ready     = valid_q & ~q1_busy_q & ~q2_busy_q;
  assign alloc_idx = first_free(valid_q);
  assign do_disp   = disp_valid && !full;

  // Oldest ready entry: age_q[i][j] set means i was allocated after j while
  // j was live, so i is oldest when no ready entry is older than it.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    sel_oh  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready[i] && ((age_q[i] & ready) == '0)) begin
        sel_vld   = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Next occupancy and age rows. A new row snapshots the live mask taken
  // before the edge; the issued entry's column is cleared in every row.
  always_comb begin
    valid_nxt = valid_q & ~sel_oh;
    if (do_disp) valid_nxt[alloc_idx] = 1'b1;
    for (int i = 0; i < RS_SIZE; i++) begin
      age_nxt[i] = age_q[i];
      if (do_disp && (alloc_idx == IDX_W'(i))) age_nxt[i] = valid_q;
      age_nxt[i] = age_nxt[i] & ~sel_oh;
    end
  end

  // ---- stage boundary: entry payload (dispatch write and CDB wakeup) ----
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (do_disp && (alloc_idx == IDX_W'(i))) begin
          op_q[i]                     <= disp_op;
          q1_q[i]                     <= disp_q1;
          q2_q[i]                     <= disp_q2;
          {q1_busy_q[i], v1_q[i]}     <= capture(disp_q1_busy, disp_q1, disp_v1);
          {q2_busy_q[i], v2_q[i]}     <= capture(disp_q2_busy, disp_q2, disp_v2);
          pc_q[i]                     <= disp_pc;
          short_q[i]                  <= disp_is_short;
          imm_q[i]                    <= disp_imm;
          rob_q[i]                    <= disp_rob_id;
        end else begin
          {q1_busy_q[i], v1_q[i]}     <= capture(q1_busy_q[i], q1_q[i], v1_q[i]);
          {q2_busy_q[i], v2_q[i]}     <= capture(q2_busy_q[i], q2_q[i], v2_q[i]);
        end
      end
    end
  end

  // ---- stage boundary: occupancy, age matrix and ALU issue register ----
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_q      <= '0;
      for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
      alu_yes      <= 1'b0;
      alu_op       <= '0;
      alu_v1       <= '0;
      alu_v2       <= '0;
      alu_pc       <= '0;
      alu_is_short <= 1'b0;
      alu_imm      <= '0;
      alu_rob_id   <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        valid_q <= '0;
        for (int i = 0; i < RS_SIZE; i++) age_q[i] <= '0;
        alu_yes <= 1'b0;
      end else begin
        valid_q <= valid_nxt;
        for (int i = 0; i < RS_SIZE; i++) age_q[i] <= age_nxt[i];
        alu_yes <= sel_vld;
        if (sel_vld) begin
          alu_op       <= op_q[sel_idx];
          alu_v1       <= v1_q[sel_idx];
          alu_v2       <= v2_q[sel_idx];
          alu_pc       <= pc_q[sel_idx];
          alu_is_short <= short_q[sel_idx];
          alu_imm      <= imm_q[sel_idx];
          alu_rob_id   <= rob_q[sel_idx];
        end
      end
    end
  end

endmodule
